// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: ROM read port plus instruction hand-off port.
// master = fetch unit side, slave = ROM/consumer side.
interface fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_req;
    logic              rom_ack;
    logic [15:0]       rom_data;
    logic [15:0]       instr_out;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output rom_addr, rom_req, instr_out, instr_pc, instr_valid,
        input  rom_ack, rom_data, instr_ready
    );

    modport slave (
        input  rom_addr, rom_req, instr_out, instr_pc, instr_valid,
        output rom_ack, rom_data, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: requests one ROM word at a time, holds it for the
// consumer, and supports single-cycle branch redirects and halting.
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rstn,
    fetch_unit_if.master      bus,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt_in,
    output logic              halted
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       instr_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              req_q;
    logic              valid_q;
    logic              halted_q;

    // pc only changes on ack or branch, so rom_addr is stable throughout REQ.
    assign bus.rom_addr    = pc;
    assign bus.rom_req     = req_q;
    assign bus.instr_out   = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = valid_q;
    assign halted          = halted_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            instr_q    <= 16'h0000;
            instr_pc_q <= '0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (branch_en) begin
                        pc    <= branch_target;
                        state <= REQ;
                        req_q <= 1'b1;
                    end else if (halt_in) begin
                        state    <= HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state <= REQ;
                        req_q <= 1'b1;
                    end
                end
                REQ: begin
                    // A branch drops any same-cycle ack; the new address restarts the request.
                    if (branch_en) begin
                        pc <= branch_target;
                    end else if (bus.rom_ack) begin
                        instr_q    <= bus.rom_data;
                        instr_pc_q <= pc;
                        pc         <= pc + 1'b1;
                        state      <= HOLD;
                        req_q      <= 1'b0;
                        valid_q    <= 1'b1;
                    end
                end
                HOLD: begin
                    if (branch_en) begin
                        pc      <= branch_target;
                        state   <= REQ;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end else if (bus.instr_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                HALT: begin
                    if (branch_en) begin
                        pc       <= branch_target;
                        state    <= REQ;
                        req_q    <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    req_q    <= 1'b0;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked
// against a transaction-level model of the delivered instruction stream.
module tb_fetch_unit;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       branch_en = 1'b0;
    logic [7:0] branch_target = 8'h00;
    logic       halt_in = 1'b0;
    logic       halted;
    logic       rom_rand = 1'b0;
    logic [15:0] mem [256];
    int n_cmp = 0;
    int n_err = 0;

    fetch_unit_if #(.ADDR_W(8)) bus ();

    fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rstn(rstn), .bus(bus), .branch_en(branch_en),
        .branch_target(branch_target), .halt_in(halt_in), .halted(halted)
    );

    always #5 clk = ~clk;

    // ROM: acks one cycle after a request (randomly later when rom_rand);
    // an address change from a branch restarts the request.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.rom_ack  <= 1'b0;
            bus.rom_data <= 16'h0000;
        end else begin
            bus.rom_ack  <= bus.rom_req && !bus.rom_ack && !branch_en &&
                            (!rom_rand || ($urandom % 2 == 1));
            bus.rom_data <= mem[bus.rom_addr];
        end
    end

    task automatic init_mem();
        for (int a = 0; a < 256; a++) mem[a] = 16'hA000 + 16'(a);
    endtask

    // Leaves the DUT in IDLE at a negedge; inputs set now act on the next edge.
    task automatic do_reset();
        rstn = 1'b0; branch_en = 1'b0; halt_in = 1'b0; bus.instr_ready = 1'b0; rom_rand = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        init_mem();
        bus.instr_ready = 1'b0;
        rstn = 1'b0;
        #2;
        n_cmp++;
        if (bus.rom_req !== 1'b0 || bus.instr_valid !== 1'b0 || halted !== 1'b0) begin
            n_err++; $display("FAIL reset_ctrl: req=%b valid=%b halted=%b, need 0/0/0", bus.rom_req, bus.instr_valid, halted);
        end
        n_cmp++;
        if (bus.instr_out !== 16'h0000 || bus.instr_pc !== 8'h00 || bus.rom_addr !== 8'h00) begin
            n_err++; $display("FAIL reset_data: out=%h ipc=%h addr=%h, need 0000/00/00", bus.instr_out, bus.instr_pc, bus.rom_addr);
        end
        do_reset();
    endtask

    task automatic test_sequence();
        int k = 0;
        logic p_valid = 1'b0, p_ack = 1'b0;
        init_mem();
        do_reset();
        bus.instr_ready = 1'b1;
        for (int c = 0; c < 60 && k < 4; c++) begin
            @(negedge clk);
            if (bus.instr_valid) begin
                n_cmp++;
                if (bus.instr_pc !== 8'(k) || bus.instr_out !== 16'hA000 + 16'(k)) begin
                    n_err++; $display("FAIL seq_data: pc=%h out=%h, need %h/%h", bus.instr_pc, bus.instr_out, 8'(k), 16'hA000 + 16'(k));
                end
                n_cmp++;
                if (p_valid !== 1'b0 || p_ack !== 1'b1) begin
                    n_err++; $display("FAIL seq_timing: prev_valid=%b prev_ack=%b, need 0/1", p_valid, p_ack);
                end
                k++;
            end
            p_valid = bus.instr_valid;
            p_ack = bus.rom_ack;
        end
        @(negedge clk);
        n_cmp++;
        if (k !== 4 || bus.instr_valid !== 1'b0) begin
            n_err++; $display("FAIL seq_count: got %0d valid=%b, need 4 and 0", k, bus.instr_valid);
        end
    endtask

    task automatic test_stall();
        int c = 0;
        init_mem();
        mem[0] = 16'h1234;
        do_reset();
        while (!bus.instr_valid && c < 30) begin @(negedge clk); c++; end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.instr_valid !== 1'b1 || bus.instr_out !== 16'h1234 || bus.instr_pc !== 8'h00 || bus.rom_req !== 1'b0) begin
                n_err++; $display("FAIL stall_hold: valid=%b out=%h pc=%h req=%b, need 1/1234/00/0", bus.instr_valid, bus.instr_out, bus.instr_pc, bus.rom_req);
            end
        end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.instr_valid !== 1'b0) begin
            n_err++; $display("FAIL stall_release: valid=%b, need 0", bus.instr_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.rom_req !== 1'b1 || bus.rom_addr !== 8'h01) begin
            n_err++; $display("FAIL stall_next: req=%b addr=%h, need 1/01", bus.rom_req, bus.rom_addr);
        end
    endtask

    task automatic test_branch_ack();
        int c = 0;
        bit hit = 0, first = 1;
        init_mem();
        do_reset();
        bus.instr_ready = 1'b1;
        branch_en = 1'b1; branch_target = 8'h05;
        @(negedge clk);
        branch_en = 1'b0;
        while (!(bus.rom_ack && bus.rom_addr == 8'h05) && c < 20) begin @(negedge clk); c++; end
        n_cmp++;
        if (bus.rom_ack !== 1'b1) begin
            n_err++; $display("FAIL br_ack_wait: ack=%b, need 1", bus.rom_ack);
        end
        branch_en = 1'b1; branch_target = 8'h40;
        @(negedge clk);
        branch_en = 1'b0;
        n_cmp++;
        if (bus.rom_req !== 1'b1 || bus.rom_addr !== 8'h40 || bus.instr_valid !== 1'b0) begin
            n_err++; $display("FAIL br_redirect: req=%b addr=%h valid=%b, need 1/40/0", bus.rom_req, bus.rom_addr, bus.instr_valid);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.instr_valid && first) begin
                first = 0; hit = 1;
                n_cmp++;
                if (bus.instr_pc !== 8'h40 || bus.instr_out !== mem[8'h40]) begin
                    n_err++; $display("FAIL br_deliver: pc=%h out=%h, need 40/%h", bus.instr_pc, bus.instr_out, mem[8'h40]);
                end
            end
        end
        n_cmp++;
        if (!hit) begin n_err++; $display("FAIL br_timeout: delivered=0, need 1"); end
    endtask

    task automatic test_wrap();
        int k = 0;
        bit seen_req = 0;
        init_mem();
        do_reset();
        bus.instr_ready = 1'b1;
        branch_en = 1'b1; branch_target = 8'hFF;
        @(negedge clk);
        branch_en = 1'b0;
        for (int c = 0; c < 30 && k < 2; c++) begin
            @(negedge clk);
            if (bus.instr_valid) begin
                n_cmp++;
                if (bus.instr_pc !== 8'hFF + 8'(k) || bus.instr_out !== mem[8'hFF + 8'(k)]) begin
                    n_err++; $display("FAIL wrap_data: pc=%h out=%h, need %h", bus.instr_pc, bus.instr_out, 8'hFF + 8'(k));
                end
                k++;
            end else if (k == 1 && bus.rom_req && !seen_req) begin
                seen_req = 1;
                n_cmp++;
                if (bus.rom_addr !== 8'h00) begin
                    n_err++; $display("FAIL wrap_addr: addr=%h, need 00", bus.rom_addr);
                end
            end
        end
        n_cmp++;
        if (k !== 2 || !seen_req) begin n_err++; $display("FAIL wrap_count: got %0d req=%0d, need 2/1", k, seen_req); end
    endtask

    task automatic test_halt();
        int c = 0;
        init_mem();
        do_reset();
        branch_en = 1'b1; branch_target = 8'h03;
        @(negedge clk);
        branch_en = 1'b0;
        while (!bus.instr_valid && c < 30) begin @(negedge clk); c++; end
        n_cmp++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h03 || bus.instr_out !== 16'hA003) begin
            n_err++; $display("FAIL halt_deliver: valid=%b pc=%h out=%h, need 1/03/A003", bus.instr_valid, bus.instr_pc, bus.instr_out);
        end
        halt_in = 1'b1; bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (halted !== 1'b1 || bus.rom_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
                n_err++; $display("FAIL halt_state: halted=%b req=%b valid=%b, need 1/0/0", halted, bus.rom_req, bus.instr_valid);
            end
            @(negedge clk);
        end
        halt_in = 1'b0;
        branch_en = 1'b1; branch_target = 8'h10;
        @(negedge clk);
        branch_en = 1'b0;
        n_cmp++;
        if (halted !== 1'b0 || bus.rom_req !== 1'b1 || bus.rom_addr !== 8'h10) begin
            n_err++; $display("FAIL halt_exit: halted=%b req=%b addr=%h, need 0/1/10", halted, bus.rom_req, bus.rom_addr);
        end
    endtask

    task automatic test_reset_mid();
        int c = 0;
        init_mem();
        do_reset();
        branch_en = 1'b1; branch_target = 8'h22;
        @(negedge clk);
        branch_en = 1'b0;
        n_cmp++;
        if (bus.rom_req !== 1'b1 || bus.rom_addr !== 8'h22) begin
            n_err++; $display("FAIL rmid_pre: req=%b addr=%h, need 1/22", bus.rom_req, bus.rom_addr);
        end
        #2 rstn = 1'b0;
        #1;
        n_cmp++;
        if (bus.rom_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.rom_addr !== 8'h00) begin
            n_err++; $display("FAIL rmid_async: req=%b valid=%b addr=%h, need 0/0/00", bus.rom_req, bus.instr_valid, bus.rom_addr);
        end
        @(negedge clk);
        rstn = 1'b1;
        while (!bus.instr_valid && c < 30) begin @(negedge clk); c++; end
        #2 rstn = 1'b0;
        #1;
        n_cmp++;
        if (bus.instr_valid !== 1'b0 || bus.instr_out !== 16'h0000) begin
            n_err++; $display("FAIL rmid_hold: valid=%b out=%h, need 0/0000", bus.instr_valid, bus.instr_out);
        end
        @(negedge clk);
        rstn = 1'b1;
        c = 0;
        while (!bus.rom_req && c < 10) begin @(negedge clk); c++; end
        n_cmp++;
        if (bus.rom_req !== 1'b1 || bus.rom_addr !== 8'h00) begin
            n_err++; $display("FAIL rmid_restart: req=%b addr=%h, need 1/00", bus.rom_req, bus.rom_addr);
        end
    endtask

    // Model: the stream of handed-off instructions is consecutive addresses,
    // restarting at the target of every branch.
    task automatic test_random();
        logic [7:0] exp_pc = 8'h00;
        logic p_valid = 0, p_ready = 0, p_branch = 0;
        logic [15:0] p_out = 0;
        logic [7:0] p_pc = 0;
        int delivered = 0;
        for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
        do_reset();
        rom_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (p_valid && !p_ready && !p_branch) begin
                n_cmp++;
                if (bus.instr_valid !== 1'b1 || bus.instr_out !== p_out || bus.instr_pc !== p_pc) begin
                    n_err++; $display("FAIL rnd_stable: valid=%b out=%h pc=%h, need 1/%h/%h", bus.instr_valid, bus.instr_out, bus.instr_pc, p_out, p_pc);
                end
            end
            if (bus.rom_req && bus.instr_valid) begin
                n_err++; n_cmp++; $display("FAIL rnd_overlap: req=1 valid=1, need not both");
            end
            bus.instr_ready = ($urandom % 2) == 1;
            branch_en = ($urandom % 12) == 0;
            branch_target = 8'($urandom);
            if (bus.instr_valid && bus.instr_ready) begin
                n_cmp++;
                if (bus.instr_pc !== exp_pc || bus.instr_out !== mem[exp_pc]) begin
                    n_err++; $display("FAIL rnd_deliver: pc=%h out=%h, need %h/%h", bus.instr_pc, bus.instr_out, exp_pc, mem[exp_pc]);
                end
                exp_pc = bus.instr_pc + 8'h01;
                delivered++;
            end
            if (branch_en) exp_pc = branch_target;
            p_valid = bus.instr_valid; p_ready = bus.instr_ready; p_branch = branch_en;
            p_out = bus.instr_out; p_pc = bus.instr_pc;
        end
        branch_en = 1'b0;
        rom_rand = 1'b0;
        n_cmp++;
        if (delivered < 50) begin n_err++; $display("FAIL rnd_progress: delivered=%0d, need >=50", delivered); end
    endtask

    initial begin
        bus.instr_ready = 1'b0;
        test_reset();
        test_sequence();
        test_stall();
        test_branch_ack();
        test_wrap();
        test_halt();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
